// File: rtl/koggestone_operand_sequencer.sv
// koggestone_operand_sequencer
//   Feeds buffered 4-bit operand pairs to an external combinational 4-bit
//   adder (tt_um_koggestone_adder4), waits SETTLE_CYCLES for it to settle,
//   captures sum/carry and offers the result on a valid/ready port.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand push handshake (in_ready = FIFO not full)
//   in_a, in_b           operand pair
//   add_a, add_b         registered operands to the adder
//   add_sum, add_carry   adder result
//   out_valid/out_ready  result handshake
//   out_sum, out_carry   captured result
//   fifo_count           FIFO occupancy 0..DEPTH
//   busy                 FSM not idle
//   carry_cnt            captures with carry set (only with KS_SEQ_CARRY_COUNT_EN)
//
// Optional feature macro: KS_SEQ_CARRY_COUNT_EN
module koggestone_operand_sequencer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_a,
  input  logic [3:0]                   in_b,
  output logic [3:0]                   add_a,
  output logic [3:0]                   add_b,
  input  logic [3:0]                   add_sum,
  input  logic                         add_carry,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_sum,
  output logic                         out_carry,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         busy
`ifdef KS_SEQ_CARRY_COUNT_EN
  ,
  output logic [CNT_W-1:0]             carry_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [3:0]       mem_a [DEPTH];
  logic [3:0]       mem_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count_next;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [SET_W-1:0] settle;
  logic [SET_W-1:0] settle_next;
  logic             pop;
  logic             capture;
  logic             release_res;
  logic             push;
  logic             empty;

  assign push  = in_valid && in_ready;
  assign empty = (fifo_count == '0);

  // Occupancy update; push and pop in one cycle cancel out.
  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + OCC_W'(1);
    end else if (!push && pop) begin
      count_next = fifo_count - OCC_W'(1);
    end
  end

  // Next-state logic and sequencing strobes.
  always_comb begin
    state_next  = state;
    settle_next = settle;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          settle_next = SET_W'(SETTLE_CYCLES);
          state_next  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle == SET_W'(1)) begin
          capture     = 1'b1;
          settle_next = '0;
          state_next  = ST_HOLD;
        end else begin
          settle_next = settle - SET_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          release_res = 1'b1;
          if (!empty) begin
            pop         = 1'b1;
            settle_next = SET_W'(SETTLE_CYCLES);
            state_next  = ST_DRIVE;
          end else begin
            state_next  = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FIFO storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // State, pointers and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b1;
      add_a      <= '0;
      add_b      <= '0;
      out_valid  <= 1'b0;
      out_sum    <= '0;
      out_carry  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      settle     <= settle_next;
      fifo_count <= count_next;
      in_ready   <= (count_next != OCC_W'(DEPTH));
      busy       <= (state_next != ST_IDLE);
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        add_a  <= mem_a[rd_ptr];
        add_b  <= mem_b[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (capture) begin
        out_sum   <= add_sum;
        out_carry <= add_carry;
        out_valid <= 1'b1;
      end else if (release_res) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef KS_SEQ_CARRY_COUNT_EN
  // Counts captured results with carry-out set; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (capture && add_carry) begin
      carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end
`else
  // CNT_W only sizes carry_cnt, which is not built in this configuration.
  if (CNT_W == 0) begin : g_no_carry_cnt
  end
`endif

endmodule

// File: tb/tb_koggestone_operand_sequencer.sv
// Testbench for koggestone_operand_sequencer: one instance with defaults
// (DEPTH=4, SETTLE_CYCLES=1) and one with SETTLE_CYCLES=3. The external
// adder is modelled as a 5-bit sum of add_a and add_b.
module tb_koggestone_operand_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default instance
  logic       in_valid, in_ready, out_valid, out_ready, out_carry, busy;
  logic [3:0] in_a, in_b, add_a, add_b, add_sum, out_sum;
  logic       add_carry;
  logic [2:0] fifo_count;
  assign {add_carry, add_sum} = 5'(add_a) + 5'(add_b);

  // SETTLE_CYCLES=3 instance
  logic       in_valid3, in_ready3, out_valid3, out_ready3, out_carry3, busy3;
  logic [3:0] in_a3, in_b3, add_a3, add_b3, add_sum3, out_sum3;
  logic       add_carry3;
  logic [2:0] fifo_count3;
  assign {add_carry3, add_sum3} = 5'(add_a3) + 5'(add_b3);

`ifdef KS_SEQ_CARRY_COUNT_EN
  logic [7:0] carry_cnt, carry_cnt3;
`endif

  koggestone_operand_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_carry(add_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carry(out_carry), .fifo_count(fifo_count), .busy(busy)
`ifdef KS_SEQ_CARRY_COUNT_EN
    , .carry_cnt(carry_cnt)
`endif
  );

  koggestone_operand_sequencer #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_a(in_a3), .in_b(in_b3),
    .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3), .add_carry(add_carry3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_sum(out_sum3),
    .out_carry(out_carry3), .fifo_count(fifo_count3), .busy(busy3)
`ifdef KS_SEQ_CARRY_COUNT_EN
    , .carry_cnt(carry_cnt3)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({add_a, add_b, out_sum, out_carry} !== 13'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {add_a, add_b, out_sum, out_carry}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Exact latency for a single pair: push edge E0, valid after E0+2.
  task automatic test_single();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4;
    @(negedge clk);                       // after E0 (push)
    in_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    @(negedge clk);                       // after E1 (pop, DRIVE)
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    n_checks++; if ({add_a, add_b} !== {4'd3, 4'd4}) begin n_fail++; $display("FAIL single_operands: got %h expected 34", {add_a, add_b}); end
    @(negedge clk);                       // after E2 (capture)
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    n_checks++; if ({out_carry, out_sum} !== 5'd7) begin n_fail++; $display("FAIL single_result: got %0d expected 7", {out_carry, out_sum}); end
    @(negedge clk);                       // after E3 (accepted)
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release: got valid=%b busy=%b expected 0 0", out_valid, busy); end
    n_checks++; if ({add_a, add_b} !== {4'd3, 4'd4}) begin n_fail++; $display("FAIL single_operands_held: got %h expected 34", {add_a, add_b}); end
  endtask

  task automatic test_carry();
    logic [3:0] va [2] = '{4'd15, 4'd15};
    logic [3:0] vb [2] = '{4'd1, 4'd15};
    logic [4:0] ve [2] = '{5'd16, 5'd30};
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      int t = 0;
      in_valid = 1'b1; in_a = va[k]; in_b = vb[k];
      @(negedge clk);
      in_valid = 1'b0;
      while (out_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL carry_timeout_%0d: got valid=%b expected 1", k, out_valid); end
      n_checks++; if ({out_carry, out_sum} !== ve[k]) begin n_fail++; $display("FAIL carry_result_%0d: got %0d expected %0d", k, {out_carry, out_sum}, ve[k]); end
      @(negedge clk);
    end
`ifdef KS_SEQ_CARRY_COUNT_EN
    n_checks++; if (carry_cnt !== 8'd2) begin n_fail++; $display("FAIL carry_cnt: got %0d expected 2", carry_cnt); end
`endif
  endtask

  // Five pairs with out_ready low: one in flight, four buffered, then full.
  task automatic test_full_and_order();
    logic [3:0] va [5] = '{4'd1, 4'd3, 4'd5, 4'd7, 4'd9};
    logic [3:0] vb [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10};
    logic [4:0] ve [5] = '{5'd3, 5'd7, 5'd11, 5'd15, 5'd19};
    int got = 0;
    int t = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_%0d: got %b expected 1", k, in_ready); end
      in_valid = 1'b1; in_a = va[k]; in_b = vb[k];
      @(negedge clk);
    end
    n_checks++; if (in_ready !== 1'b0 || fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_state: got ready=%b count=%0d expected 0 4", in_ready, fifo_count); end
    in_a = 4'd11; in_b = 4'd12;           // refused extra pair
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_checks++; if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold_count_%0d: got count=%0d ready=%b expected 4 0", k, fifo_count, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || {out_carry, out_sum} !== 5'd3) begin n_fail++; $display("FAIL hold_stable_%0d: got valid=%b result=%0d expected 1 3", k, out_valid, {out_carry, out_sum}); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (got < 5 && t < 60) begin
      if (out_valid === 1'b1) begin
        n_checks++; if ({out_carry, out_sum} !== ve[got]) begin n_fail++; $display("FAIL order_%0d: got %0d expected %0d", got, {out_carry, out_sum}, ve[got]); end
        got++;
      end
      @(negedge clk); t++;
    end
    n_checks++; if (got != 5) begin n_fail++; $display("FAIL order_count: got %0d expected 5", got); end
    repeat (4) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL order_drained: got valid=%b count=%0d busy=%b expected 0 0 0", out_valid, fifo_count, busy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 4'd2; in_b = 4'd3;
    @(negedge clk);
    in_a = 4'd4; in_b = 4'd5;
    @(negedge clk);                       // pair 0 in DRIVE, pair 1 buffered
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL mid_pre: got busy=%b count=%0d expected 1 1", busy, fifo_count); end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got valid=%b count=%0d busy=%b expected 0 0 0", out_valid, fifo_count, busy); end
    n_checks++; if ({add_a, add_b} !== 8'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ops: got ops=%h ready=%b expected 00 1", {add_a, add_b}, in_ready); end
`ifdef KS_SEQ_CARRY_COUNT_EN
    n_checks++; if (carry_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d expected 0", carry_cnt); end
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_discard: got valid=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  // All 256 operand pairs through the SETTLE_CYCLES=3 instance.
  task automatic test_back_to_back();
    out_ready3 = 1'b1;
    fork
      begin : producer
        int i = 0;
        int t = 0;
        logic rdy = 1'b0;
        while (i < 256 && t < 5000) begin
          @(negedge clk); t++;
          if (in_valid3 && rdy) i++;
          if (i < 256) begin
            in_valid3 = 1'b1; in_a3 = 4'(i >> 4); in_b3 = 4'(i);
            rdy = in_ready3;
          end else begin
            in_valid3 = 1'b0;
          end
        end
        in_valid3 = 1'b0;
      end
      begin : consumer
        int j = 0;
        int t = 0;
        int last = 0;
        logic [7:0] ij;
        while (j < 256 && t < 5000) begin
          @(negedge clk); t++;
          if (out_valid3 === 1'b1) begin
            ij = 8'(j);
            n_checks++;
            if ({out_carry3, out_sum3} !== 5'(ij[7:4]) + 5'(ij[3:0])) begin
              n_fail++; $display("FAIL b2b_result_%0d: got %0d expected %0d", j, {out_carry3, out_sum3}, 5'(ij[7:4]) + 5'(ij[3:0]));
            end
            if (j > 0) begin
              n_checks++; if (cyc - last != 4) begin n_fail++; $display("FAIL b2b_interval_%0d: got %0d expected 4", j, cyc - last); end
            end
            last = cyc;
            j++;
          end
        end
        n_checks++; if (j != 256) begin n_fail++; $display("FAIL b2b_count: got %0d expected 256", j); end
      end
    join
  endtask

  initial begin
    in_valid = 0; in_a = 0; in_b = 0; out_ready = 0;
    in_valid3 = 0; in_a3 = 0; in_b3 = 0; out_ready3 = 0;
    test_reset();
    test_single();
    test_carry();
    test_full_and_order();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
